sobel_frame_writer: RTL and testbench

Sink for the sobel kernel's output pixel stream. It captures the (IMG_WIDTH−2)×(IMG_HEIGHT−2) interior result pixels, writes them into a frame-buffer write port at their true image positions, then fills the one-pixel border with zeros and pulses a frame-complete flag. It sits between the kernel's `grayscale_o`/`done_o` outputs and the output frame memory.

---
 rtl/sobel_frame_writer.sv | 175 +++++++++++++++++
 tb/tb_sobel_frame_writer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_writer.sv
//==============================================================================
// Module      : sobel_frame_writer
// Description : Sink for the sobel kernel result stream. Captures the
//               (IMG_WIDTH-2)x(IMG_HEIGHT-2) interior pixels and writes them to
//               a frame-buffer write port at their true row-major positions,
//               then writes zeros over the one-pixel border and pulses
//               frame_done_o.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               start_i           - arm capture of one frame (IDLE only)
//               grayscale_i       - result pixel from the kernel
//               done_i            - pixel-valid strobe, one pixel per cycle
//               wr_en_o/wr_addr_o/wr_data_o - frame-buffer write port
//               busy_o            - high while capturing or filling border
//               frame_done_o      - one-cycle completion pulse
//               overflow_o        - sticky: pixel arrived outside capture
// Options     : `define SOBEL_WRITER_THRESHOLD_EN to binarize captured pixels
//               against THRESHOLD (>= THRESHOLD -> 8'hFF, else 8'h00).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sobel_frame_writer #(
    parameter int         IMG_WIDTH  = 320,
    parameter int         IMG_HEIGHT = 240,
    parameter int         ADDR_W     = 17,
    parameter logic [7:0] THRESHOLD  = 8'd64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [7:0]        grayscale_i,
    input  logic              done_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic              overflow_o
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_capture = 2'd1;
    localparam logic [1:0] c_border  = 2'd2;
    localparam logic [1:0] c_done    = 2'd3;

    localparam logic [ADDR_W-1:0] c_first_addr = ADDR_W'(IMG_WIDTH + 1);
    localparam logic [ADDR_W-1:0] c_pix_last   = ADDR_W'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2) - 1);
    localparam logic [ADDR_W-1:0] c_row_skip   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_side_step  = ADDR_W'(IMG_WIDTH - 1);
    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);
    localparam logic [COL_W-1:0]  c_col_wrap   = COL_W'(IMG_WIDTH - 3);
    localparam logic [COL_W-1:0]  c_col_max    = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0]  c_col_one    = COL_W'(1);
    localparam logic [ROW_W-1:0]  c_row_max    = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0]  c_row_one    = ROW_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;     // capture address, reused as border address
    logic [COL_W-1:0]  r_col;      // interior column in CAPTURE, image column in BORDER
    logic [ROW_W-1:0]  r_row;      // image row during BORDER
    logic [ADDR_W-1:0] r_pix_cnt;  // interior pixels accepted so far
    logic [7:0]        w_pix_data;

`ifdef SOBEL_WRITER_THRESHOLD_EN
    assign w_pix_data = (grayscale_i >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    logic w_unused_threshold;
    assign w_pix_data         = grayscale_i;
    assign w_unused_threshold = ^THRESHOLD;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_idle;
            r_addr       <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_pix_cnt    <= '0;
            wr_en_o      <= 1'b0;
            wr_addr_o    <= '0;
            wr_data_o    <= 8'h00;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            wr_en_o      <= 1'b0;
            frame_done_o <= 1'b0;

            // Any pixel outside CAPTURE is dropped and flagged; an accepted
            // start_i below overrides this so the new frame begins clean.
            if (done_i && (r_state != c_capture)) begin
                overflow_o <= 1'b1;
            end

            case (r_state)
                c_idle: begin
                    if (start_i) begin
                        r_state    <= c_capture;
                        busy_o     <= 1'b1;
                        overflow_o <= 1'b0;
                        r_addr     <= c_first_addr;
                        r_col      <= '0;
                        r_pix_cnt  <= '0;
                    end
                end

                c_capture: begin
                    if (done_i) begin
                        wr_en_o   <= 1'b1;
                        wr_addr_o <= r_addr;
                        wr_data_o <= w_pix_data;
                        // End of interior row: jump over right border of this
                        // row and left border of the next one.
                        if (r_col == c_col_wrap) begin
                            r_col  <= '0;
                            r_addr <= r_addr + c_row_skip;
                        end else begin
                            r_col  <= r_col + c_col_one;
                            r_addr <= r_addr + c_addr_one;
                        end
                        if (r_pix_cnt == c_pix_last) begin
                            r_state <= c_border;
                            r_addr  <= '0;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + c_addr_one;
                        end
                    end
                end

                c_border: begin
                    wr_en_o   <= 1'b1;
                    wr_addr_o <= r_addr;
                    wr_data_o <= 8'h00;
                    if ((r_row == '0) || (r_row == c_row_max)) begin
                        // Top and bottom rows are written in full.
                        r_addr <= r_addr + c_addr_one;
                        if (r_col == c_col_max) begin
                            r_col <= '0;
                            r_row <= r_row + c_row_one;
                            if (r_row == c_row_max) begin
                                r_state <= c_done;
                            end
                        end else begin
                            r_col <= r_col + c_col_one;
                        end
                    end else if (r_col == '0) begin
                        // Side rows: left pixel, then jump to the right pixel.
                        r_col  <= c_col_max;
                        r_addr <= r_addr + c_side_step;
                    end else begin
                        r_col  <= '0;
                        r_row  <= r_row + c_row_one;
                        r_addr <= r_addr + c_addr_one;
                    end
                end

                c_done: begin
                    frame_done_o <= 1'b1;
                    busy_o       <= 1'b0;
                    r_state      <= c_idle;
                end

                default: r_state <= c_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sobel_frame_writer.sv
//==============================================================================
// Module      : tb_sobel_frame_writer
// Description : Self-checking bench for sobel_frame_writer on a 5x4 image.
//               Expected write addresses come from image geometry, expected
//               timing from the one-cycle registered-output rule.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sobel_frame_writer;

    localparam int W     = 5;
    localparam int H     = 4;
    localparam int AW    = 5;
    localparam int NPIX  = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [7:0]    grayscale_i;
    logic          done_i;
    logic          wr_en_o;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    wr_data_o;
    logic          busy_o;
    logic          frame_done_o;
    logic          overflow_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_ovf = 1'b0;
    logic [7:0] pix [0:NPIX-1];

    sobel_frame_writer #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .ADDR_W    (AW),
        .THRESHOLD (8'd64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .grayscale_i (grayscale_i),
        .done_i      (done_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_pix(input logic [7:0] g);
`ifdef SOBEL_WRITER_THRESHOLD_EN
        return (g >= 8'd64) ? 8'hFF : 8'h00;
`else
        return g;
`endif
    endfunction

    // One full frame from IDLE: interior pixels from pix[], gap cycles between
    // them drawn from [gmin,gmax]; optionally stray done_i pulses in BORDER.
    task automatic run_frame(input int gmin, input int gmax, input bit stray);
        int ia[$];
        int ba[$];
        int gap;
        logic d;
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++) ia.push_back(r * W + c);
        for (int c = 0; c < W; c++) ba.push_back(c);
        for (int r = 1; r <= H - 2; r++) begin
            ba.push_back(r * W);
            ba.push_back(r * W + W - 1);
        end
        for (int c = 0; c < W; c++) ba.push_back((H - 1) * W + c);

        @(negedge clk);
        start_i = 1'b1;
        done_i  = 1'b0;
        @(posedge clk); #1;
        exp_ovf = 1'b0;
        check("start_busy", busy_o, 1'b1);
        check("start_wr_en", wr_en_o, 1'b0);
        check("start_ovf_clr", overflow_o, exp_ovf);

        for (int i = 0; i < NPIX; i++) begin
            gap = $urandom_range(gmax, gmin);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                done_i  = 1'b0;
                start_i = 1'($urandom_range(1, 0));
                @(posedge clk); #1;
                check("gap_wr_en", wr_en_o, 1'b0);
                check("gap_busy", busy_o, 1'b1);
            end
            @(negedge clk);
            done_i      = 1'b1;
            grayscale_i = pix[i];
            start_i     = 1'($urandom_range(1, 0));
            @(posedge clk); #1;
            check("pix_wr_en", wr_en_o, 1'b1);
            check("pix_addr", wr_addr_o, ia[i]);
            check("pix_data", wr_data_o, exp_pix(pix[i]));
            check("pix_busy", busy_o, 1'b1);
        end

        for (int j = 0; j < ba.size(); j++) begin
            @(negedge clk);
            start_i = 1'b0;
            d = stray ? 1'($urandom_range(3, 0) == 0) : 1'b0;
            done_i = d;
            grayscale_i = 8'($urandom);
            if (d) exp_ovf = 1'b1;
            @(posedge clk); #1;
            check("bdr_wr_en", wr_en_o, 1'b1);
            check("bdr_addr", wr_addr_o, ba[j]);
            check("bdr_data", wr_data_o, 8'h00);
            check("bdr_busy", busy_o, 1'b1);
            check("bdr_fdone", frame_done_o, 1'b0);
            check("bdr_ovf", overflow_o, exp_ovf);
        end

        @(negedge clk);
        done_i = 1'b0;
        @(posedge clk); #1;
        check("fdone_pulse", frame_done_o, 1'b1);
        check("fdone_busy", busy_o, 1'b0);
        check("fdone_wr_en", wr_en_o, 1'b0);
        check("fdone_addr_hold", wr_addr_o, ba[ba.size() - 1]);
        check("fdone_ovf", overflow_o, exp_ovf);
        @(posedge clk); #1;
        check("fdone_low", frame_done_o, 1'b0);
        check("idle_wr_en", wr_en_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst         = 1'b1;
        start_i     = 1'b0;
        done_i      = 1'b0;
        grayscale_i = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en_o, 1'b0);
        check("rst_addr", wr_addr_o, 0);
        check("rst_data", wr_data_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        check("rst_fdone", frame_done_o, 1'b0);
        check("rst_ovf", overflow_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back pixels 10..15.
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(10 + i);
        run_frame(0, 0, 1'b0);
        // Same pixels, done_i every third cycle.
        run_frame(2, 2, 1'b0);

        // Stray pixel in IDLE, cleared by the next start.
        @(negedge clk);
        done_i      = 1'b1;
        grayscale_i = 8'd55;
        @(posedge clk); #1;
        check("idle_drop_wr_en", wr_en_o, 1'b0);
        check("idle_ovf_set", overflow_o, 1'b1);
        @(negedge clk);
        done_i = 1'b0;
        @(posedge clk); #1;
        check("idle_ovf_hold", overflow_o, 1'b1);

        pix[0] = 8'd63; pix[1] = 8'd64; pix[2] = 8'd200;
        pix[3] = 8'd0;  pix[4] = 8'd255; pix[5] = 8'd100;
        run_frame(0, 1, 1'b0);

        // Reset after three pixels abandons the frame.
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            done_i      = 1'b1;
            grayscale_i = 8'(k + 1);
            @(negedge clk);
        end
        done_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en_o, 1'b0);
        check("mid_rst_addr", wr_addr_o, 0);
        check("mid_rst_data", wr_data_o, 8'h00);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_fdone", frame_done_o, 1'b0);
        check("mid_rst_ovf", overflow_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post_rst_fdone", frame_done_o, 1'b0);
            check("post_rst_busy", busy_o, 1'b0);
        end
        exp_ovf = 1'b0;
        for (int i = 0; i < NPIX; i++) pix[i] = 8'(20 + i);
        run_frame(0, 0, 1'b0);

        // Randomized frames with random gaps and stray pixels during BORDER.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom);
            run_frame(0, 3, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
